// File: rtl/memory_stage_pkg.sv
// Shared definitions for the Y86-64 memory stage: instruction codes, FSM encoding
// and small decode helpers used by both the stage and its bench.
package memory_stage_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 8;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] icode);
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: is_mem_op = 1'b1;
      default:                                            is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_write(input logic [3:0] icode);
    case (icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: is_write = 1'b1;
      default:                   is_write = 1'b0;
    endcase
  endfunction

  // ret and popq address the stack through valA; everything else uses valE.
  function automatic logic addr_from_vala(input logic [3:0] icode);
    addr_from_vala = (icode == I_RET) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/memory_stage_dmem_byte_ram.sv
// Byte-wide data memory: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module dmem_byte_ram #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: serialises each 8-byte data access into eight byte
// transfers over the internal RAM and reports completion with a done pulse.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start; request latched on the accepting edge
//   ST_XFER | moving byte cnt at addr+cnt, little-endian, one per cycle
//   ST_DONE | done pulse; valM and dmem_error valid for the sequencer
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        busy,
  output logic        done,
  output logic        dmem_error
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - WORD_BYTES);

  state_t        state, state_next;
  logic [2:0]    cnt;
  logic [3:0]    icode_q;
  logic [AW-1:0] addr_q;
  logic [63:0]   data_q;

  logic [63:0]   req_addr;
  logic          req_mem;
  logic          req_fault;
  logic          accept;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  // Full 64-bit compare so addresses near 2^64 fault instead of wrapping.
  always_comb begin
    req_addr  = addr_from_vala(icode) ? valA : valE;
    req_mem   = is_mem_op(icode);
    req_fault = req_mem && (req_addr > MAX_ADDR);
    accept    = (state == ST_IDLE) && start;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = (req_mem && !req_fault) ? ST_XFER : ST_DONE;
      end
      ST_XFER: begin
        if (cnt == 3'd7) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 3'd0;
      icode_q    <= 4'h0;
      addr_q     <= '0;
      data_q     <= 64'd0;
      valM       <= 64'd0;
      dmem_error <= 1'b0;
    end else if (accept) begin
      cnt        <= 3'd0;
      icode_q    <= icode;
      addr_q     <= req_addr[AW-1:0];
      data_q     <= (icode == I_CALL) ? valP : valA;
      dmem_error <= req_fault;
    end else if (state == ST_XFER) begin
      if (!is_write(icode_q)) valM[{cnt, 3'b000} +: BYTE_W] <= ram_rdata;
      cnt <= cnt + 3'd1;
    end
  end

  // Reset suppresses the write on its own edge so an abort never stores an extra byte.
  always_comb begin
    ram_addr  = addr_q + AW'(cnt);
    ram_wdata = data_q[{cnt, 3'b000} +: BYTE_W];
    ram_we    = (state == ST_XFER) && is_write(icode_q) && !reset;
  end

  dmem_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_addr),
    .wdata (ram_wdata),
    .raddr (ram_addr),
    .rdata (ram_rdata)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a byte-level memory model predicts each access,
// pushes the expectation into a scoreboard and checks it when done appears.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic [63:0] valM;
  logic        busy, done, dmem_error;

  always #5 clk = ~clk;

  memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .icode      (icode),
    .valA       (valA),
    .valE       (valE),
    .valP       (valP),
    .valM       (valM),
    .busy       (busy),
    .done       (done),
    .dmem_error (dmem_error)
  );

  typedef struct {
    string       tag;
    logic [63:0] valM;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model_mem [MEM_BYTES];
  logic [63:0] model_valM;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_and_push(input string tag, input logic [3:0] ic,
                                input logic [63:0] a, input logic [63:0] e, input logic [63:0] p);
    exp_t        x;
    logic [63:0] addr, wd;
    bit          mem, wr, fault;
    mem   = ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
    wr    = ic inside {I_RMMOVQ, I_CALL, I_PUSHQ};
    addr  = (ic == I_RET || ic == I_POPQ) ? a : e;
    fault = mem && (addr > 64'(MEM_BYTES - 8));
    wd    = (ic == I_CALL) ? p : a;
    if (mem && !fault) begin
      for (int i = 0; i < 8; i++) begin
        if (wr) model_mem[int'(addr) + i] = wd[8*i +: 8];
        else    model_valM[8*i +: 8]      = model_mem[int'(addr) + i];
      end
    end
    x.tag  = tag;
    x.err  = fault;
    x.lat  = (mem && !fault) ? 9 : 1;
    x.valM = model_valM;
    sb.push_back(x);
    start = 1'b1;
    icode = ic;
    valA  = a;
    valE  = e;
    valP  = p;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ic, input logic [63:0] a,
                        input logic [63:0] e, input logic [63:0] p, input bit repulse);
    exp_t x;
    int   lat;
    @(posedge clk); #1;
    drive_and_push(tag, ic, a, e, p);
    @(posedge clk); #1;
    start = 1'b0;
    icode = 4'($urandom);
    valA  = {$urandom, $urandom};
    valE  = {$urandom, $urandom};
    valP  = {$urandom, $urandom};
    lat   = 1;
    while (done !== 1'b1 && lat < 20) begin
      if (repulse && lat == 3) begin
        start = 1'b1;
        icode = I_RMMOVQ;
        valE  = 64'h0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    x = sb.pop_front();
    check({x.tag, " latency"}, 64'(lat), 64'(x.lat));
    check({x.tag, " valM"}, valM, x.valM);
    check({x.tag, " dmem_error"}, {63'd0, dmem_error}, {63'd0, x.err});
    @(posedge clk); #1;
    check({x.tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
    check({x.tag, " idle_after"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    bit seen_done;
    for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
    model_valM = 64'd0;
    reset = 1'b1;
    start = 1'b0;
    icode = 4'h0;
    valA  = 64'd0;
    valE  = 64'd0;
    valP  = 64'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset valM", valM, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset err", {63'd0, dmem_error}, 64'd0);

    run_op("rmmovq10", I_RMMOVQ, 64'h1122334455667788, 64'h10, 64'h0, 1'b0);
    run_op("mrmovq10", I_MRMOVQ, 64'h0, 64'h10, 64'h0, 1'b0);
    run_op("pushq", I_PUSHQ, 64'hDEAD, 64'h1F8, 64'h0, 1'b0);
    run_op("popq", I_POPQ, 64'h1F8, 64'h3C0, 64'h0, 1'b0);
    run_op("call", I_CALL, 64'h7777, 64'h100, 64'h40, 1'b0);
    run_op("ret", I_RET, 64'h100, 64'h0, 64'h0, 1'b0);
    run_op("fault_m7", I_MRMOVQ, 64'h0, 64'(MEM_BYTES - 7), 64'h0, 1'b0);
    run_op("fault_wrap", I_MRMOVQ, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0);
    run_op("fault_popq", I_POPQ, 64'h1_0000_0000, 64'h10, 64'h0, 1'b0);
    run_op("fault_wr", I_RMMOVQ, 64'h0BAD, 64'(MEM_BYTES - 1), 64'h0, 1'b0);
    run_op("top_wr", I_RMMOVQ, 64'hCAFE_F00D_0123_4567, 64'(MEM_BYTES - 8), 64'h0, 1'b0);
    run_op("top_rd", I_MRMOVQ, 64'h0, 64'(MEM_BYTES - 8), 64'h0, 1'b0);
    run_op("opq", 4'h6, 64'h10, 64'h10, 64'h10, 1'b0);
    run_op("reread10", I_MRMOVQ, 64'h0, 64'h10, 64'h0, 1'b0);
    run_op("repulse", I_RMMOVQ, 64'h0102030405060708, 64'h30, 64'h0, 1'b1);
    run_op("reread30", I_MRMOVQ, 64'h0, 64'h30, 64'h0, 1'b0);
    run_op("reread10b", I_MRMOVQ, 64'h0, 64'h10, 64'h0, 1'b0);

    // Aborted store: reset lands after three XFER edges.
    run_op("pre20", I_RMMOVQ, 64'h5555_5555_5555_5555, 64'h20, 64'h0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    icode = I_RMMOVQ;
    valA  = 64'hAABBCCDDEEFF0011;
    valE  = 64'h20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_mem[32'h20] = 8'h11;
    model_mem[32'h21] = 8'h00;
    model_mem[32'h22] = 8'hFF;
    @(posedge clk); #1;
    reset = 1'b0;
    model_valM = 64'd0;
    check("abort valM", valM, 64'd0);
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort err", {63'd0, dmem_error}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort no_done", {63'd0, seen_done}, 64'd0);
    run_op("read20", I_MRMOVQ, 64'h0, 64'h20, 64'h0, 1'b0);
    check("read20 literal", valM, 64'h5555_5555_55FF_0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
